// File: rtl/fperm_pkg.sv
// Shared types and constants for the fperm issue scheduler slice.
package fperm_pkg;

    localparam int unsigned FPW            = 68;
    localparam int unsigned FPERM_LAT_FAST = 1;
    localparam int unsigned FPERM_LAT_SLOW = 3;

    typedef enum logic [2:0] {
        FPERM_COPYA   = 3'd0,
        FPERM_COPYB   = 3'd1,
        FPERM_SWPA    = 3'd2,
        FPERM_SWPB    = 3'd3,
        FPERM_DUPA    = 3'd4,
        FPERM_DUPB    = 3'd5,
        FPERM_RCPSEED = 3'd6,
        FPERM_RSQSEED = 3'd7
    } fperm_op_e;

    typedef struct packed {
        logic copyA;
        logic swpSngl;
        logic dupSngl;
        logic is_sqrt;
        logic is_div;
    } fperm_ctl_t;

endpackage

// File: rtl/fperm_op_dec.sv
// Opcode to fperm control-pin decoder (purely combinational).
module fperm_op_dec
    import fperm_pkg::*;
(
    input  fperm_op_e  op,
    output fperm_ctl_t ctl
);

    always_comb begin
        ctl = '0;
        case (op)
            FPERM_COPYA:   ctl.copyA = 1'b1;
            FPERM_COPYB:   ;
            FPERM_SWPA:    begin ctl.copyA = 1'b1; ctl.swpSngl = 1'b1; end
            FPERM_SWPB:    ctl.swpSngl = 1'b1;
            FPERM_DUPA:    begin ctl.copyA = 1'b1; ctl.dupSngl = 1'b1; end
            FPERM_DUPB:    ctl.dupSngl = 1'b1;
            FPERM_RCPSEED: ctl.is_div = 1'b1;
            FPERM_RSQSEED: ctl.is_sqrt = 1'b1;
        endcase
    end

endmodule

// File: rtl/fperm_sched.sv
// Two-port round-robin issue scheduler for the shared fperm unit, with a
// latency-matched in-flight pipe that produces the tagged writeback valid.
module fperm_sched
    import fperm_pkg::*;
#(
    parameter int unsigned LAT  = FPERM_LAT_FAST,
    parameter int unsigned TAGW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_vld,
    input  logic [2:0]      req0_op,
    input  logic [TAGW-1:0] req0_tag,
    input  logic [FPW-1:0]  req0_A,
    input  logic [FPW-1:0]  req0_B,
    output logic            req0_rdy,
    input  logic            req1_vld,
    input  logic [2:0]      req1_op,
    input  logic [TAGW-1:0] req1_tag,
    input  logic [FPW-1:0]  req1_A,
    input  logic [FPW-1:0]  req1_B,
    output logic            req1_rdy,
    input  logic            ext_rsv,
    input  logic            flush,
    output logic            en,
    output logic            copyA,
    output logic            swpSngl,
    output logic            dupSngl,
    output logic            is_sqrt,
    output logic            is_div,
    output logic [FPW-1:0]  A,
    output logic [FPW-1:0]  B,
    output logic            wb_vld,
    output logic [TAGW-1:0] wb_tag,
    output logic            wb_port
);

    logic                      ptr;
    logic                      gnt0, gnt1, accept;
    logic                      slot_taken, can_issue;
    fperm_op_e                 sel_op;
    fperm_ctl_t                sel_ctl, ctl_q;
    logic [LAT-1:0]            pipe_vld;
    logic [LAT-1:0]            pipe_port;
    logic [LAT-1:0][TAGW-1:0]  pipe_tag;

    // ptr=0 favours port 0 when both ports request
    always_comb begin
        gnt0 = req0_vld & (~req1_vld | ~ptr);
        gnt1 = req1_vld & (~req0_vld | ptr);
    end

    // Fixed latency with single issue can never collide on the writeback slot;
    // kept as a hook for future variable-latency ops.
    assign slot_taken = 1'b0;
    assign can_issue  = ~flush & ~ext_rsv & ~slot_taken;
    assign req0_rdy   = gnt0 & can_issue;
    assign req1_rdy   = gnt1 & can_issue;
    assign accept     = req0_rdy | req1_rdy;
    assign sel_op     = fperm_op_e'(gnt1 ? req1_op : req0_op);

    fperm_op_dec u_dec (
        .op  (sel_op),
        .ctl (sel_ctl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= req0_rdy;
        end
    end

    // Operands and controls hold their last value when nothing issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en    <= 1'b0;
            ctl_q <= '0;
            A     <= '0;
            B     <= '0;
        end else begin
            en <= accept;
            if (accept) begin
                ctl_q <= sel_ctl;
                A     <= gnt1 ? req1_A : req0_A;
                B     <= gnt1 ? req1_B : req0_B;
            end
        end
    end

    assign copyA   = ctl_q.copyA;
    assign swpSngl = ctl_q.swpSngl;
    assign dupSngl = ctl_q.dupSngl;
    assign is_sqrt = ctl_q.is_sqrt;
    assign is_div  = ctl_q.is_div;

    // A result already in the wb register during flush is left on the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
            pipe_tag  <= '0;
            wb_vld    <= 1'b0;
            wb_tag    <= '0;
            wb_port   <= 1'b0;
        end else begin
            pipe_vld[0]  <= accept;
            pipe_tag[0]  <= gnt1 ? req1_tag : req0_tag;
            pipe_port[0] <= gnt1;
            for (int unsigned k = 1; k < LAT; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1] & ~flush;
                pipe_tag[k]  <= pipe_tag[k-1];
                pipe_port[k] <= pipe_port[k-1];
            end
            wb_vld  <= pipe_vld[LAT-1] & ~flush;
            wb_tag  <= pipe_tag[LAT-1];
            wb_port <= pipe_port[LAT-1];
        end
    end

endmodule

// File: tb/tb_fperm_sched.sv
// Bench for fperm_sched: LAT=1 and LAT=3 builds driven in parallel, checked
// every cycle against a queue-based model plus directed literal checks.
module tb_fperm_sched;
    import fperm_pkg::*;

    localparam int unsigned TAGW = 9;

    typedef struct {
        logic [2:0]      op;
        logic [TAGW-1:0] tag;
        logic [FPW-1:0]  a;
        logic [FPW-1:0]  b;
    } item_t;

    typedef struct {
        int              due;
        logic [TAGW-1:0] tag;
        logic            port;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            req0_vld = 1'b0, req1_vld = 1'b0;
    logic [2:0]      req0_op = '0, req1_op = '0;
    logic [TAGW-1:0] req0_tag = '0, req1_tag = '0;
    logic [FPW-1:0]  req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
    logic            ext_rsv = 1'b0, flush = 1'b0;

    logic            rdy0_1, rdy1_1, en_1, cA_1, sw_1, du_1, sq_1, dv_1, wbv_1, wbp_1;
    logic [FPW-1:0]  A_1, B_1;
    logic [TAGW-1:0] wbt_1;
    logic            rdy0_3, rdy1_3, en_3, cA_3, sw_3, du_3, sq_3, dv_3, wbv_3, wbp_3;
    logic [FPW-1:0]  A_3, B_3;
    logic [TAGW-1:0] wbt_3;

    fperm_sched #(.LAT(1), .TAGW(TAGW)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_op(req0_op), .req0_tag(req0_tag),
        .req0_A(req0_A), .req0_B(req0_B), .req0_rdy(rdy0_1),
        .req1_vld(req1_vld), .req1_op(req1_op), .req1_tag(req1_tag),
        .req1_A(req1_A), .req1_B(req1_B), .req1_rdy(rdy1_1),
        .ext_rsv(ext_rsv), .flush(flush), .en(en_1),
        .copyA(cA_1), .swpSngl(sw_1), .dupSngl(du_1), .is_sqrt(sq_1), .is_div(dv_1),
        .A(A_1), .B(B_1), .wb_vld(wbv_1), .wb_tag(wbt_1), .wb_port(wbp_1)
    );

    fperm_sched #(.LAT(3), .TAGW(TAGW)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_op(req0_op), .req0_tag(req0_tag),
        .req0_A(req0_A), .req0_B(req0_B), .req0_rdy(rdy0_3),
        .req1_vld(req1_vld), .req1_op(req1_op), .req1_tag(req1_tag),
        .req1_A(req1_A), .req1_B(req1_B), .req1_rdy(rdy1_3),
        .ext_rsv(ext_rsv), .flush(flush), .en(en_3),
        .copyA(cA_3), .swpSngl(sw_3), .dupSngl(du_3), .is_sqrt(sq_3), .is_div(dv_3),
        .A(A_3), .B(B_3), .wb_vld(wbv_3), .wb_tag(wbt_3), .wb_port(wbp_3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [2:0] op, input logic [TAGW-1:0] tag);
        item_t it;
        it.op  = op;
        it.tag = tag;
        it.a   = {4'($urandom), $urandom, $urandom};
        it.b   = {4'($urandom), $urandom, $urandom};
        return it;
    endfunction

    // Requesters: present queued items, hold each until rdy is seen at an edge.
    item_t pend0[$], pend1[$];
    initial begin
        logic s0, s1;
        item_t it;
        forever begin
            @(negedge clk);
            s0 = rdy0_3;
            s1 = rdy1_3;
            @(posedge clk);
            #1;
            if (req0_vld && s0) req0_vld = 1'b0;
            if (req1_vld && s1) req1_vld = 1'b0;
            if (!req0_vld && pend0.size() > 0) begin
                it = pend0.pop_front();
                req0_vld = 1'b1; req0_op = it.op; req0_tag = it.tag; req0_A = it.a; req0_B = it.b;
            end
            if (!req1_vld && pend1.size() > 0) begin
                it = pend1.pop_front();
                req1_vld = 1'b1; req1_op = it.op; req1_tag = it.tag; req1_A = it.a; req1_B = it.b;
            end
        end
    end

    // Reference model: control bits {copyA, swpSngl, dupSngl, is_sqrt, is_div} per opcode.
    logic [4:0] ctl_tab [8] = '{5'b10000, 5'b00000, 5'b11000, 5'b01000,
                                5'b10100, 5'b00100, 5'b00001, 5'b00010};

    task automatic chk_wb(input string sfx, input int n, input ent_t q[$],
                          input logic v, input logic [TAGW-1:0] t, input logic p);
        logic ev;
        ent_t e;
        ev = 1'b0;
        e  = '{0, '0, 1'b0};
        foreach (q[i]) if (q[i].due == n) begin ev = 1'b1; e = q[i]; end
        chk1({"wb_vld", sfx}, v, ev);
        if (ev) begin
            chkw({"wb_tag", sfx}, 128'(t), 128'(e.tag));
            chk1({"wb_port", sfx}, p, e.port);
        end
    endtask

    initial begin
        int         n;
        logic       m_ptr, m_en, g0, g1, can;
        logic [4:0] m_ctl;
        logic [FPW-1:0] m_A, m_B;
        ent_t       q1[$], q3[$];
        n = 0; m_ptr = 1'b0; m_en = 1'b0; m_ctl = '0; m_A = '0; m_B = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                q1.delete(); q3.delete();
                m_ptr = 1'b0; m_en = 1'b0; m_ctl = '0; m_A = '0; m_B = '0;
                chk1("rst_en_1", en_1, 1'b0);   chk1("rst_en_3", en_3, 1'b0);
                chk1("rst_wbv_1", wbv_1, 1'b0); chk1("rst_wbv_3", wbv_3, 1'b0);
                chkw("rst_A_1", 128'(A_1), 128'(0)); chkw("rst_A_3", 128'(A_3), 128'(0));
            end else begin
                g0  = req0_vld && (!req1_vld || !m_ptr);
                g1  = req1_vld && (!req0_vld || m_ptr);
                can = !flush && !ext_rsv;
                chk1("rdy0_1", rdy0_1, g0 && can); chk1("rdy1_1", rdy1_1, g1 && can);
                chk1("rdy0_3", rdy0_3, g0 && can); chk1("rdy1_3", rdy1_3, g1 && can);
                chk1("en_1", en_1, m_en); chk1("en_3", en_3, m_en);
                chkw("ctl_1", 128'({cA_1, sw_1, du_1, sq_1, dv_1}), 128'(m_ctl));
                chkw("ctl_3", 128'({cA_3, sw_3, du_3, sq_3, dv_3}), 128'(m_ctl));
                chkw("A_1", 128'(A_1), 128'(m_A)); chkw("B_1", 128'(B_1), 128'(m_B));
                chkw("A_3", 128'(A_3), 128'(m_A)); chkw("B_3", 128'(B_3), 128'(m_B));
                chk_wb("_1", n, q1, wbv_1, wbt_1, wbp_1);
                chk_wb("_3", n, q3, wbv_3, wbt_3, wbp_3);
                if (flush) begin
                    q1.delete(); q3.delete();
                end else begin
                    q1 = q1.find(x) with (x.due > n);
                    q3 = q3.find(x) with (x.due > n);
                end
                if (can && (g0 || g1)) begin
                    q1.push_back('{n + 2, g1 ? req1_tag : req0_tag, g1});
                    q3.push_back('{n + 4, g1 ? req1_tag : req0_tag, g1});
                    m_en  = 1'b1;
                    m_ctl = ctl_tab[g1 ? req1_op : req0_op];
                    m_A   = g1 ? req1_A : req0_A;
                    m_B   = g1 ? req1_B : req0_B;
                    m_ptr = g0;
                end else begin
                    m_en = 1'b0;
                end
            end
            n++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [TAGW-1:0] cont_exp [4];

    initial begin
        cont_exp = '{9'h001, 9'h011, 9'h002, 9'h012};
        repeat (3) @(posedge clk);
        #3;
        chk1("reset_en", en_1, 1'b0);
        chk1("reset_wbv", wbv_3, 1'b0);
        rst = 1'b1;

        // Contention from reset: grants alternate starting with port 0.
        @(negedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            pend0.push_back(mk(3'($urandom_range(0, 7)), 9'(i)));
            pend1.push_back(mk(3'($urandom_range(0, 7)), 9'(16 + i)));
        end
        @(posedge clk); #3;
        chk1("cont_rdy0_t0", rdy0_1, 1'b1);
        chk1("cont_rdy1_t0", rdy1_1, 1'b0);
        @(posedge clk); #3;
        chk1("cont_rdy1_t1", rdy1_1, 1'b1);
        @(posedge clk); #3;
        for (int i = 0; i < 4; i++) begin
            chk1("cont_wbv", wbv_1, 1'b1);
            chkw("cont_wbtag", 128'(wbt_1), 128'(cont_exp[i]));
            @(posedge clk); #3;
        end
        repeat (10) @(posedge clk);

        // LAT=3 streaming: eight back-to-back port-1 ops.
        @(negedge clk); #1;
        for (int i = 0; i < 8; i++) pend1.push_back(mk(3'($urandom_range(0, 7)), 9'(i)));
        @(posedge clk); #3;
        repeat (3) @(posedge clk);
        #3;
        chk1("stream_pre", wbv_3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #3;
            chk1("stream_wbv", wbv_3, 1'b1);
            chkw("stream_tag", 128'(wbt_3), 128'(i));
        end
        @(posedge clk); #3;
        chk1("stream_post", wbv_3, 1'b0);
        repeat (4) @(posedge clk);

        // Single SWPA op on port 0.
        @(negedge clk); #1;
        pend0.push_back(mk(3'd2, 9'h015));
        @(posedge clk); #3;
        chk1("single_rdy", rdy0_1, 1'b1);
        @(posedge clk); #3;
        chk1("single_en", en_1, 1'b1);
        chkw("single_ctl", 128'({cA_1, sw_1, du_1, sq_1, dv_1}), 128'(5'b11000));
        @(posedge clk); #3;
        chk1("single_wbv1", wbv_1, 1'b1);
        chkw("single_tag1", 128'(wbt_1), 128'(9'h015));
        chk1("single_port1", wbp_1, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        chk1("single_wbv3", wbv_3, 1'b1);
        chkw("single_tag3", 128'(wbt_3), 128'(9'h015));
        repeat (4) @(posedge clk);

        // Reservation stalls the only pending request by one cycle.
        @(negedge clk); #1;
        pend0.push_back(mk(3'd6, 9'h0AA));
        @(posedge clk); #2; ext_rsv = 1'b1; #1;
        chk1("rsv_rdy", rdy0_1, 1'b0);
        @(posedge clk); #2; ext_rsv = 1'b0; #1;
        chk1("rsv_en", en_1, 1'b0);
        chk1("rsv_rdy_after", rdy0_1, 1'b1);
        @(posedge clk); #3;
        chk1("rsv_en_after", en_1, 1'b1);
        repeat (6) @(posedge clk);

        // Flush in the cycle tag 0xA is on the bus (LAT=3): only 0xA appears.
        @(negedge clk); #1;
        pend0.push_back(mk(3'd0, 9'h00A));
        pend0.push_back(mk(3'd1, 9'h00B));
        pend0.push_back(mk(3'd7, 9'h00C));
        @(posedge clk); #3;
        repeat (4) @(posedge clk);
        #2; flush = 1'b1; #1;
        chk1("flush_wbv_due", wbv_3, 1'b1);
        chkw("flush_tag_due", 128'(wbt_3), 128'(9'h00A));
        @(posedge clk); #2; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk1("flush_killed", wbv_3, 1'b0);
            @(posedge clk); #2;
        end
        repeat (4) @(posedge clk);

        // Async reset with two ops in flight.
        @(negedge clk); #1;
        pend0.push_back(mk(3'd4, 9'h031));
        pend0.push_back(mk(3'd5, 9'h032));
        @(posedge clk); #3;
        @(posedge clk); #3;
        @(posedge clk); #3;
        chk1("arst_en_before", en_3, 1'b1);
        rst = 1'b0; #1;
        chk1("arst_en_1", en_1, 1'b0);
        chk1("arst_en_3", en_3, 1'b0);
        chk1("arst_wbv_1", wbv_1, 1'b0);
        chkw("arst_A_3", 128'(A_3), 128'(0));
        @(posedge clk); #2; rst = 1'b1;
        @(negedge clk); #1;
        pend0.push_back(mk(3'd3, 9'h041));
        pend1.push_back(mk(3'd3, 9'h141));
        @(posedge clk); #3;
        chk1("arst_ptr_rdy0", rdy0_3, 1'b1);
        chk1("arst_ptr_rdy1", rdy1_3, 1'b0);
        chk1("arst_no_wb", wbv_3, 1'b0);
        repeat (8) @(posedge clk);

        // Random traffic with flush and reservation pulses.
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #2;
            flush   = ($urandom_range(0, 9) == 0);
            ext_rsv = ($urandom_range(0, 7) == 0);
            if (pend0.size() < 2 && $urandom_range(0, 2) != 0)
                pend0.push_back(mk(3'($urandom_range(0, 7)), 9'($urandom_range(0, 511))));
            if (pend1.size() < 2 && $urandom_range(0, 2) != 0)
                pend1.push_back(mk(3'($urandom_range(0, 7)), 9'($urandom_range(0, 511))));
        end
        @(posedge clk); #2;
        flush = 1'b0; ext_rsv = 1'b0;
        begin
            int budget;
            budget = 100;
            while ((pend0.size() > 0 || pend1.size() > 0 || req0_vld || req1_vld) && budget > 0) begin
                @(posedge clk); #2;
                budget--;
            end
            chk1("drain_done", budget > 0, 1'b1);
        end
        repeat (8) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
